// File: rtl/sim_pkg.sv
// sim_pkg -- shared types and constants for the simulation run controller.
//   state_e       : run-controller FSM states (IDLE, RESET, RUN, DONE)
//   VERDICT_*     : one-hot verdict encoding held while a run is DONE
package sim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int          VERDICT_W       = 3;
    localparam logic [2:0]  VERDICT_NONE    = 3'b000;
    localparam logic [2:0]  VERDICT_PASS    = 3'b001;
    localparam logic [2:0]  VERDICT_FAIL    = 3'b010;
    localparam logic [2:0]  VERDICT_TIMEOUT = 3'b100;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up-counter that sticks at all-ones instead of wrapping.
//   i_Clk     : clock
//   i_Reset   : synchronous active-high reset to zero
//   i_Clear   : synchronous clear to zero (wins over i_Enable)
//   i_Enable  : count up by one this cycle
//   o_Count   : registered count value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_Clear,
    input  logic         i_Enable,
    output logic [W-1:0] o_Count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_Clear) begin
            count_d = '0;
        end else if (i_Enable && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Count = count_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl -- sequences a core under test through reset and run, watches
// for the tohost exit write and reports pass / fail / timeout.
//   i_Clk, i_Reset          : clock, synchronous active-high reset
//   i_Start                 : one-cycle request to (re)start a run (IDLE/DONE only)
//   i_MemWrite/Addr/WData   : core data-memory write port, snooped for tohost
//   i_Retire                : one pulse per retired instruction
//   o_CoreReset             : reset to the core, low only while running
//   o_Running, o_Done       : FSM is in RUN / DONE
//   o_Pass/o_Fail/o_Timeout : one-hot verdict while o_Done
//   o_ExitCode              : failing test number (tohost data >> 1)
//   o_CycleCount            : RUN cycles elapsed (saturating)
//   o_RetireCount           : instructions retired during RUN (saturating)
//   o_DbgState              : current FSM state for observation
module sim_run_ctrl
    import sim_pkg::*;
#(
    parameter int                RST_CYCLES  = 2,
    parameter int                MAX_CYCLES  = 100,
    parameter int                CNT_W       = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_0100)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic              i_MemWrite,
    input  logic [ADDR_W-1:0] i_MemAddr,
    input  logic [DATA_W-1:0] i_MemWData,
    input  logic              i_Retire,
    output logic              o_CoreReset,
    output logic              o_Running,
    output logic              o_Done,
    output logic              o_Pass,
    output logic              o_Fail,
    output logic              o_Timeout,
    output logic [DATA_W-2:0] o_ExitCode,
    output logic [CNT_W-1:0]  o_CycleCount,
    output logic [CNT_W-1:0]  o_RetireCount,
    output state_e            o_DbgState
);

    localparam int              RC_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST   = RC_W'(RST_CYCLES - 1);
    // Timeout fires in the RUN cycle whose increment brings the count to
    // MAX_CYCLES; comparing in 64 bits keeps this correct for any CNT_W.
    localparam logic [63:0]     TIMEOUT_AT = 64'(MAX_CYCLES) - 64'd1;

    state_e                 state_q;
    logic [RC_W-1:0]        rst_cnt_q;
    logic [VERDICT_W-1:0]   verdict_q;
    logic [DATA_W-2:0]      exit_code_q;
    logic                   core_reset_q;
    logic                   running_q;
    logic                   done_q;

    logic [CNT_W-1:0]       cycle_cnt;
    logic [CNT_W-1:0]       retire_cnt;

    logic                   start_ok;
    logic                   in_run;
    logic                   tohost_wr;
    logic                   tohost_pass;
    logic                   timeout_hit;

    // Start is honoured only from IDLE or DONE; it also clears the counters.
    assign start_ok    = i_Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_run      = (state_q == ST_RUN);
    // A tohost write of zero is not an exit request.
    assign tohost_wr   = in_run && i_MemWrite && (i_MemAddr == TOHOST_ADDR)
                         && (i_MemWData != '0);
    assign tohost_pass = (i_MemWData == DATA_W'(1));
    assign timeout_hit = in_run && (64'(cycle_cnt) == TIMEOUT_AT);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Clear  (start_ok),
        .i_Enable (in_run),
        .o_Count  (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Clear  (start_ok),
        .i_Enable (in_run && i_Retire),
        .o_Count  (retire_cnt)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            verdict_q    <= VERDICT_NONE;
            exit_code_q  <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_q     <= ST_RESET;
                        rst_cnt_q   <= '0;
                        verdict_q   <= VERDICT_NONE;
                        exit_code_q <= '0;
                        done_q      <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q      <= ST_RUN;
                        core_reset_q <= 1'b0;
                        running_q    <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RC_W'(1);
                    end
                end
                ST_RUN: begin
                    // The tohost check comes first so an exit write on the
                    // timeout cycle still yields pass/fail.
                    if (tohost_wr || timeout_hit) begin
                        state_q      <= ST_DONE;
                        core_reset_q <= 1'b1;
                        running_q    <= 1'b0;
                        done_q       <= 1'b1;
                        if (tohost_wr) begin
                            if (tohost_pass) begin
                                verdict_q <= VERDICT_PASS;
                            end else begin
                                verdict_q   <= VERDICT_FAIL;
                                exit_code_q <= i_MemWData[DATA_W-1:1];
                            end
                        end else begin
                            verdict_q <= VERDICT_TIMEOUT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_CoreReset   = core_reset_q;
    assign o_Running     = running_q;
    assign o_Done        = done_q;
    assign o_Pass        = |(verdict_q & VERDICT_PASS);
    assign o_Fail        = |(verdict_q & VERDICT_FAIL);
    assign o_Timeout     = |(verdict_q & VERDICT_TIMEOUT);
    assign o_ExitCode    = exit_code_q;
    assign o_CycleCount  = cycle_cnt;
    assign o_RetireCount = retire_cnt;
    assign o_DbgState    = state_q;

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2, number of cycles o_CoreReset is held asserted after a start; legal range 1 and up.
REQ-002 Parameter MAX_CYCLES, default 100, RUN-state cycle budget before timeout; legal range 1 and up.
REQ-003 Parameter CNT_W, default 32, width of the cycle and retire counters.
REQ-004 Parameter ADDR_W, default 32, core data-memory address width.
REQ-005 Parameter DATA_W, default 32, core data-memory write-data width.
REQ-006 Parameter TOHOST_ADDR, default 32'h0000_0100, magic address for test-exit writes.
REQ-007 i_Clk  input  1  sole clock; all state changes on the rising edge.
REQ-008 i_Reset  input  1  synchronous, active-high reset of this block.
REQ-009 i_Start  input  1  single-cycle request to begin a run.
REQ-010 i_MemWrite  input  1  core data-memory write strobe.
REQ-011 i_MemAddr  input  ADDR_W  core data-memory address.
REQ-012 i_MemWData  input  DATA_W  core data-memory write data.
REQ-013 i_Retire  input  1  one-cycle pulse per retired instruction.
REQ-014 o_CoreReset  output  1  active-high synchronous reset driven to the core.
REQ-015 o_Running  output  1  high while in RUN.
REQ-016 o_Done  output  1  high while in DONE.
REQ-017 o_Pass, o_Fail, o_Timeout  output  1 each  run verdict, one-hot while o_Done is high, otherwise 0.
REQ-018 o_ExitCode  output  DATA_W-1  failing test number, i_MemWData>>1 as captured.
REQ-019 o_CycleCount, o_RetireCount  output  CNT_W each  RUN cycles elapsed, instructions retired.

Function
REQ-020 FSM states: IDLE, RESET, RUN, DONE; registered outputs only.
REQ-021 IDLE: o_CoreReset=1; i_Start moves to RESET, clears counters, verdicts and o_ExitCode.
REQ-022 RESET: o_CoreReset=1 for exactly RST_CYCLES cycles, then RUN; o_CoreReset=0 from the first RUN cycle.
REQ-023 RUN: o_CycleCount increments by 1 each cycle; o_RetireCount increments on i_Retire; both saturate at all-ones.
REQ-024 A write with i_MemWrite=1, i_MemAddr==TOHOST_ADDR and i_MemWData==1 in RUN moves to DONE with o_Pass=1.
REQ-025 A tohost write with any other nonzero data moves to DONE with o_Fail=1 and o_ExitCode=i_MemWData>>1.
REQ-026 A tohost write with data 0, or a write to any other address, is ignored.
REQ-027 On the cycle o_CycleCount would reach MAX_CYCLES with no qualifying tohost write, move to DONE with o_Timeout=1.
REQ-028 A tohost write in the same cycle as the timeout takes priority, and the verdict is pass or fail, not timeout.
REQ-029 A retire pulse coincident with the terminating cycle is counted.
REQ-030 DONE: o_CoreReset=1 and counters/verdict frozen; i_Start moves to RESET, acting as restart.
REQ-031 i_Start in RESET or RUN is ignored.
REQ-032 Transition latency: verdict outputs are valid the cycle after the terminating event.

Reset
REQ-033 i_Reset=1 on a rising edge forces IDLE from any state, including mid-RUN, and takes priority over i_Start.
REQ-034 Reset values: o_CoreReset=1, all other outputs 0, all counters 0.

Structure
REQ-035 The shared package sim_pkg holds the state enum type and the verdict encoding constants.
REQ-036 Sub-module sat_counter (parametrised width, enable, clear, saturate) is instantiated twice for the cycle and retire counters.
REQ-037 The block is simulation and FPGA bring-up infrastructure; it contains no `$finish` and leaves that to the bench.

Verification
REQ-038 Reset, start, RST_CYCLES=2: o_CoreReset=1 for 2 cycles after start, then 0, and o_Running=1.
REQ-039 In RUN, a write of 1 to 0x100 after 40 cycles -> o_Done=1, o_Pass=1, o_CycleCount=40 frozen.
REQ-040 A write of 7 to 0x100 -> o_Fail=1, o_ExitCode=3; a write of 0 to 0x100 and a write of 1 to 0x104 -> no effect.
REQ-041 MAX_CYCLES=100 with no tohost write -> o_Timeout=1 and o_CycleCount=100; a tohost write on cycle 100 -> o_Pass=1, o_Timeout=0.
REQ-042 i_Reset pulsed mid-RUN -> next cycle IDLE, o_CoreReset=1, counters 0; i_Start in DONE restarts with cleared verdict.
REQ-043 CNT_W=4 with 20 retire pulses -> o_RetireCount holds at 15.
